// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD add/subtract datapath.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_NINE = 4'd9;
  localparam int MAX_NDIG = 32;

  typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;

  // Vectors narrower than MAX_NDIG digits are zero-extended by the caller.
  function automatic logic [DIGIT_W-1:0] digit_at(input logic [DIGIT_W*MAX_NDIG-1:0] vec,
                                                  input int unsigned i);
    return vec[i*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One decimal digit of addition: x + y + cin with BCD correction.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               cin,
  output logic [DIGIT_W-1:0] digit,
  output logic               cout
);

  logic [DIGIT_W:0] sum;
  logic [DIGIT_W:0] adj;

  // Adding 6 skips the six unused codes, so the low bits land on s-10.
  always_comb begin
    sum = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, cin};
    adj = sum + (DIGIT_W+1)'(6);
    if (sum > (DIGIT_W+1)'(9)) begin
      digit = adj[DIGIT_W-1:0];
      cout  = 1'b1;
    end else begin
      digit = sum[DIGIT_W-1:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor, LSD first, with a recomplement pass for negative results.
// Optional operand digit checking is built when BCD_DIGIT_CHECK_EN is defined.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic [DIGIT_W*NDIG-1:0] a,
  input  logic [DIGIT_W*NDIG-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [DIGIT_W*NDIG-1:0] result,
  output logic                    sign,
  output logic                    cout,
  output logic                    err
);

  localparam int W  = DIGIT_W*NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int XW = DIGIT_W*MAX_NDIG;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG-1);

  state_t           state;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic             mode_r;
  logic [IW-1:0]    idx;
  logic             carry;

  logic [DIGIT_W-1:0] x;
  logic [DIGIT_W-1:0] y;
  logic [DIGIT_W-1:0] bdig;
  logic [DIGIT_W-1:0] dsum;
  logic               dcarry;
  logic               last;
  logic               to_done;

  // ADD feeds a and (possibly complemented) b; FIX complements the stored result.
  always_comb begin
    bdig = digit_at(XW'(b_r), 32'(idx));
    if (state == FIX) begin
      x = BCD_NINE - digit_at(XW'(result), 32'(idx));
      y = '0;
    end else begin
      x = digit_at(XW'(a_r), 32'(idx));
      y = mode_r ? (BCD_NINE - bdig) : bdig;
    end
    last    = (idx == LAST_IDX);
    to_done = ((state == ADD) && last && (!mode_r || dcarry)) ||
              ((state == FIX) && last);
  end

  bcd_digit_adder u_digit (
    .x     (x),
    .y     (y),
    .cin   (carry),
    .digit (dsum),
    .cout  (dcarry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      mode_r <= 1'b0;
      idx    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      sign   <= 1'b0;
      cout   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            mode_r <= mode;
            idx    <= '0;
            carry  <= mode;
            result <= '0;
            sign   <= 1'b0;
            cout   <= 1'b0;
            busy   <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          result[idx*DIGIT_W +: DIGIT_W] <= dsum;
          carry <= dcarry;
          idx   <= idx + 1'b1;
          if (last) begin
            if (!mode_r) begin
              cout <= dcarry;
            end else if (!dcarry) begin
              // No end-around carry means the 10's complement result is negative.
              sign  <= 1'b1;
              idx   <= '0;
              carry <= 1'b1;
              state <= FIX;
            end
          end
          if (to_done) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        FIX: begin
          result[idx*DIGIT_W +: DIGIT_W] <= dsum;
          carry <= dcarry;
          idx   <= idx + 1'b1;
          if (to_done) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic bad;
  logic err_q;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (a_r[i*DIGIT_W +: DIGIT_W] > BCD_NINE || b_r[i*DIGIT_W +: DIGIT_W] > BCD_NINE)
        bad = 1'b1;
    end
  end

  // Flag is captured alongside done so it stays valid with the result.
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if ((state == IDLE || state == DONE) && start)
      err_q <= 1'b0;
    else if (to_done)
      err_q <= bad;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed self-checking bench for bcd_serial_addsub with NDIG=4.
module tb_bcd_serial_addsub;

  localparam int NDIG = 4;
  localparam int W = 4*NDIG;
  localparam int TIMEOUT = 50;

  logic         clk;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         sign;
  logic         cout;
  logic         err;

  int tests_run;
  int tests_failed;

  bcd_serial_addsub #(.NDIG(NDIG)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .sign   (sign),
    .cout   (cout),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Latency is counted in clock edges, the start-sampling edge being edge 1.
  task automatic applyStimulus(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic vmode, input bit check_val, input logic [W-1:0] exp_res,
                               input logic exp_sign, input logic exp_cout, input logic exp_err,
                               input int exp_lat, input bit interfere);
    int  cycles;
    bit  busy_ok;
    @(negedge clk);
    a     = va;
    b     = vb;
    mode  = vmode;
    start = 1'b1;
    @(posedge clk);
    cycles  = 1;
    busy_ok = 1'b1;
    #1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    while (!done && cycles < TIMEOUT) begin
      if (!busy) busy_ok = 1'b0;
      if (interfere && cycles == 2) begin
        a     = 16'h9999;
        b     = 16'h0001;
        mode  = ~vmode;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      cycles++;
      #1;
    end
    start = 1'b0;
    checkOutput({tag, " latency"}, 32'(cycles), 32'(exp_lat));
    checkOutput({tag, " busy"}, 32'(busy_ok), 32'd1);
    checkOutput({tag, " busy at done"}, 32'(busy), 32'd0);
    if (check_val) begin
      checkOutput({tag, " result"}, 32'(result), 32'(exp_res));
      checkOutput({tag, " sign"}, 32'(sign), 32'(exp_sign));
      checkOutput({tag, " cout"}, 32'(cout), 32'(exp_cout));
    end
    checkOutput({tag, " err"}, 32'(err), 32'(exp_err));
    @(posedge clk);
    #1;
    checkOutput({tag, " done pulse"}, 32'(done), 32'd0);
    if (check_val)
      checkOutput({tag, " result held"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset result", 32'(result), 32'd0);
    checkOutput("reset flags", {29'd0, sign, cout, err}, 32'd0);
    rst = 1'b0;

    applyStimulus("add", 16'h1234, 16'h5678, 1'b0, 1'b1, 16'h6912, 1'b0, 1'b0, 1'b0, 5, 1'b0);
    applyStimulus("add ovf", 16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 5, 1'b0);
    applyStimulus("sub pos", 16'h5000, 16'h1234, 1'b1, 1'b1, 16'h3766, 1'b0, 1'b0, 1'b0, 5, 1'b0);
    applyStimulus("sub neg", 16'h1234, 16'h5000, 1'b1, 1'b1, 16'h3766, 1'b1, 1'b0, 1'b0, 9, 1'b0);
    applyStimulus("sub zero", 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 5, 1'b0);
    applyStimulus("sub neg2", 16'h0001, 16'h0010, 1'b1, 1'b1, 16'h0009, 1'b1, 1'b0, 1'b0, 9, 1'b0);
    applyStimulus("start busy", 16'h1234, 16'h5678, 1'b0, 1'b1, 16'h6912, 1'b0, 1'b0, 1'b0, 5, 1'b1);

    // Reset two cycles into an addition must clear everything and leave the FSM idle.
    @(negedge clk);
    a     = 16'h1234;
    b     = 16'h5678;
    mode  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("mid rst busy", 32'(busy), 32'd0);
    checkOutput("mid rst done", 32'(done), 32'd0);
    checkOutput("mid rst result", 32'(result), 32'd0);
    checkOutput("mid rst flags", {29'd0, sign, cout, err}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("idle after rst", {30'd0, busy, done}, 32'd0);

    applyStimulus("after rst", 16'h0999, 16'h0001, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 5, 1'b0);
`ifdef BCD_DIGIT_CHECK_EN
    applyStimulus("bad digit", 16'h12A4, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 5, 1'b0);
`else
    applyStimulus("bad digit", 16'h12A4, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 5, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
